// File: rtl/pattern_matcher_param.sv
// ---------------------------------------------------------------------------
// pattern_matcher_param
//
// Serial pattern detector with a run-time loadable pattern, a don't-care mask
// and an overlap mode. Valid-qualified input bits shift into a PAT_W-bit
// history (newest bit at the LSB). A registered one-cycle pulse on `found`
// flags each match, and a saturating counter records how many matches there
// have been.
//
// Parameters
//   PAT_W        pattern/history width in bits (>= 2)
//   CNT_W        match counter width in bits (>= 1)
//   DEF_PATTERN  pattern loaded by reset
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset, overrides everything else
//   bit_valid    bit_stream is sampled this cycle
//   bit_stream   serial data bit
//   cfg_load     load cfg_* this cycle (clears history and statistics)
//   cfg_pattern  new pattern, bit PAT_W-1 is the oldest bit
//   cfg_mask     1 = compare this position, 0 = don't care
//   cfg_overlap  1 = successive matches may share bits
//   found        one-cycle match pulse, one cycle after the completing bit
//   match_count  saturating number of matches
//   count_sat    sticky, set once match_count reaches all-ones
// ---------------------------------------------------------------------------
module pattern_matcher_param #(
  parameter int unsigned        PAT_W       = 4,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [PAT_W-1:0]   DEF_PATTERN = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_stream,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  output logic             found,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // Fill must be able to hold the value PAT_W itself.
  localparam int unsigned    FillW   = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  logic [PAT_W-1:0] hist_q,    hist_d;
  logic [FillW-1:0] fill_q,    fill_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] mask_q,    mask_d;
  logic             overlap_q, overlap_d;
  logic             found_q,   found_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             sat_q,     sat_d;

  // Candidate values for an accepted bit.
  logic [PAT_W-1:0] hist_shift;
  logic [FillW-1:0] fill_inc;
  logic             armed_next;
  logic             hit;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_stream};
    // Fill saturates at PAT_W; reaching it means the history is fully valid.
    fill_inc   = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
    armed_next = (fill_inc == FillFull);
    hit        = armed_next && (((hist_shift ^ pattern_q) & mask_q) == '0);
  end

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    found_d   = 1'b0;
    count_d   = count_q;
    sat_d     = sat_q;

    if (cfg_load) begin
      // New configuration starts from a clean slate; a bit offered in the
      // same cycle is dropped.
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      sat_d     = 1'b0;
    end else if (bit_valid) begin
      hist_d  = hist_shift;
      // Non-overlap mode returns to FILLING so the next match needs PAT_W
      // fresh bits; the history itself keeps shifting.
      fill_d  = (hit && !overlap_q) ? '0 : fill_inc;
      found_d = hit;
      if (hit && (count_q != CntMax)) begin
        count_d = count_q + 1'b1;
      end
      if (hit && (count_d == CntMax)) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      mask_q    <= '1;
      overlap_q <= 1'b1;
      found_q   <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      found_q   <= found_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  assign found       = found_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_pattern_matcher_param.sv
// ---------------------------------------------------------------------------
// Bench for pattern_matcher_param. Two instances share the stimulus: one with
// an 8-bit counter and one with a 2-bit counter to reach saturation quickly.
// The reference model keeps the list of accepted bits and matches the last
// PAT_W of them against pattern/mask directly.
// ---------------------------------------------------------------------------
module tb_pattern_matcher_param;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_stream = 1'b0;
  logic          cfg_load = 1'b0;
  logic [PW-1:0] cfg_pattern = 4'b1101;
  logic [PW-1:0] cfg_mask = 4'b1111;
  logic          cfg_overlap = 1'b1;
  logic          found, found2;
  logic [7:0]    match_count;
  logic [1:0]    match_count2;
  logic          count_sat, count_sat2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pattern_matcher_param #(.PAT_W(4), .CNT_W(8), .DEF_PATTERN(4'b1101)) u_dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_stream(bit_stream),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .found(found), .match_count(match_count),
    .count_sat(count_sat)
  );

  pattern_matcher_param #(.PAT_W(4), .CNT_W(2), .DEF_PATTERN(4'b1101)) u_dut2 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_stream(bit_stream),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .found(found2), .match_count(match_count2),
    .count_sat(count_sat2)
  );

  // ---------------- reference model ----------------
  bit          acc_q[$];     // accepted bits since last clear, newest at end
  int          fresh;        // bits accepted since clear or non-overlap match
  logic [3:0]  m_pat  = 4'b1101;
  logic [3:0]  m_mask = 4'b1111;
  bit          m_ov   = 1'b1;
  bit          e_found;
  int          e_cnt, e_cnt2;
  bit          e_sat, e_sat2;

  function automatic bit model_hit();
    if (fresh < PW) return 1'b0;
    for (int k = 0; k < PW; k++) begin
      // k = 0 is the newest bit, compared against pattern bit 0
      if (m_mask[k] && (acc_q[acc_q.size() - 1 - k] != m_pat[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_clear_stats();
    acc_q.delete();
    fresh   = 0;
    e_found = 1'b0;
    e_cnt   = 0;
    e_cnt2  = 0;
    e_sat   = 1'b0;
    e_sat2  = 1'b0;
  endfunction

  // Drive one cycle, then advance the model to the post-edge state.
  task automatic cyc(input bit r, input bit ld, input bit v, input bit b);
    rst = r; cfg_load = ld; bit_valid = v; bit_stream = b;
    @(posedge clk);
    #1;
    if (r) begin
      model_clear_stats();
      m_pat = 4'b1101; m_mask = 4'b1111; m_ov = 1'b1;
    end else if (ld) begin
      model_clear_stats();
      m_pat = cfg_pattern; m_mask = cfg_mask; m_ov = cfg_overlap;
    end else if (v) begin
      acc_q.push_back(b);
      if (acc_q.size() > 64) void'(acc_q.pop_front());
      fresh++;
      e_found = model_hit();
      if (e_found) begin
        if (e_cnt < 255) e_cnt++;
        if (e_cnt2 < 3) e_cnt2++;
        if (e_cnt == 255) e_sat = 1'b1;
        if (e_cnt2 == 3) e_sat2 = 1'b1;
        if (!m_ov) fresh = 0;
      end
    end else begin
      e_found = 1'b0;
    end
    rst = 1'b0; cfg_load = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [3:0] p, input logic [3:0] m, input bit ov);
    cfg_pattern = p; cfg_mask = m; cfg_overlap = ov;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (found !== 1'b0) begin n_err++; $display("FAIL reset_found got=%b want=0", found); end
    n_cmp++;
    if (match_count !== 8'd0) begin
      n_err++; $display("FAIL reset_count got=%0d want=0", match_count);
    end
    n_cmp++;
    if (count_sat !== 1'b0 || count_sat2 !== 1'b0) begin
      n_err++; $display("FAIL reset_sat got=%b/%b want=0/0", count_sat, count_sat2);
    end
  endtask

  task automatic test_overlap();
    bit s[7]  = '{1, 1, 0, 1, 1, 0, 1};
    bit ef[7] = '{0, 0, 0, 1, 0, 0, 1};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, s[i]);
      n_cmp++;
      if (found !== ef[i]) begin
        n_err++; $display("FAIL overlap_found bit=%0d got=%b want=%b", i + 1, found, ef[i]);
      end
    end
    n_cmp++;
    if (match_count !== 8'd2) begin
      n_err++; $display("FAIL overlap_count got=%0d want=2", match_count);
    end
  endtask

  task automatic test_non_overlap();
    bit s[7]  = '{1, 1, 0, 1, 1, 0, 1};
    bit ef[7] = '{0, 0, 0, 1, 0, 0, 0};
    load_cfg(4'b1101, 4'b1111, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, s[i]);
      n_cmp++;
      if (found !== ef[i]) begin
        n_err++; $display("FAIL nonovl_found bit=%0d got=%b want=%b", i + 1, found, ef[i]);
      end
    end
    n_cmp++;
    if (match_count !== 8'd1) begin
      n_err++; $display("FAIL nonovl_count got=%0d want=1", match_count);
    end
  endtask

  task automatic test_gap();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (found !== 1'b0) begin n_err++; $display("FAIL gap_idle cyc=%0d got=%b want=0", i, found); end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (found !== 1'b0) begin n_err++; $display("FAIL gap_bit3 got=%b want=0", found); end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (found !== 1'b1) begin n_err++; $display("FAIL gap_bit4 got=%b want=1", found); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (found !== 1'b0 || match_count !== 8'd1) begin
      n_err++; $display("FAIL gap_after got=%b/%0d want=0/1", found, match_count);
    end
  endtask

  task automatic test_mask();
    bit s[8] = '{1, 1, 1, 1, 0, 1, 1, 0};
    load_cfg(4'b1001, 4'b1001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, s[i]);
      n_cmp++;
      if (found !== e_found) begin
        n_err++; $display("FAIL mask_found bit=%0d got=%b want=%b", i + 1, found, e_found);
      end
      if (i == 3) begin
        n_cmp++;
        if (found !== 1'b1) begin n_err++; $display("FAIL mask_1111 got=%b want=1", found); end
      end
      if (i == 7) begin
        n_cmp++;
        if (found !== 1'b0) begin n_err++; $display("FAIL mask_0110 got=%b want=0", found); end
      end
    end
  endtask

  task automatic test_saturate();
    int ec[8] = '{0, 0, 0, 1, 2, 3, 3, 3};
    bit es[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    load_cfg(4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (match_count2 !== 2'(ec[i]) || count_sat2 !== es[i]) begin
        n_err++;
        $display("FAIL sat_cnt2 bit=%0d got=%0d/%b want=%0d/%b", i + 1, match_count2,
                 count_sat2, ec[i], es[i]);
      end
      n_cmp++;
      if (found2 !== (i >= 3)) begin
        n_err++; $display("FAIL sat_found bit=%0d got=%b want=%b", i + 1, found2, i >= 3);
      end
    end
    n_cmp++;
    if (match_count !== 8'd5 || count_sat !== 1'b0) begin
      n_err++; $display("FAIL sat_cnt8 got=%0d/%b want=5/0", match_count, count_sat);
    end
  endtask

  task automatic test_restart();
    bit s[4] = '{1, 1, 0, 1};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, s[i]);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (found !== 1'b0) begin n_err++; $display("FAIL restart_rst got=%b want=0", found); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, s[i]);
      n_cmp++;
      if (found !== (i == 3)) begin
        n_err++; $display("FAIL restart_seq bit=%0d got=%b want=%b", i + 1, found, i == 3);
      end
    end
    // Same again with cfg_load, offering a bit in the load cycle.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, s[i]);
    cfg_pattern = 4'b1101; cfg_mask = 4'b1111; cfg_overlap = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (found !== 1'b0 || match_count !== 8'd0) begin
      n_err++; $display("FAIL restart_load got=%b/%0d want=0/0", found, match_count);
    end
    // If the load-cycle bit were kept, 1,0,1 would complete 1101.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (found !== 1'b0 || match_count !== 8'd0) begin
      n_err++; $display("FAIL restart_dropbit got=%b/%0d want=0/0", found, match_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
      end else if ($urandom_range(49) == 0) begin
        cfg_pattern = 4'($urandom);
        cfg_mask    = ($urandom_range(5) == 0) ? 4'b0000 : 4'($urandom);
        cfg_overlap = 1'($urandom);
        cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      end else begin
        cyc(1'b0, 1'b0, ($urandom_range(9) < 7), 1'($urandom));
      end
      n_cmp++;
      if (found !== e_found || found2 !== e_found) begin
        n_err++; $display("FAIL rand_found i=%0d got=%b/%b want=%b", i, found, found2, e_found);
      end
      n_cmp++;
      if (match_count !== 8'(e_cnt) || count_sat !== e_sat) begin
        n_err++;
        $display("FAIL rand_cnt8 i=%0d got=%0d/%b want=%0d/%b", i, match_count, count_sat,
                 e_cnt, e_sat);
      end
      n_cmp++;
      if (match_count2 !== 2'(e_cnt2) || count_sat2 !== e_sat2) begin
        n_err++;
        $display("FAIL rand_cnt2 i=%0d got=%0d/%b want=%0d/%b", i, match_count2, count_sat2,
                 e_cnt2, e_sat2);
      end
    end
  endtask

  initial begin
    model_clear_stats();
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gap();
    test_mask();
    test_saturate();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_matcher_param.md
Name: pattern_matcher_param

Overview:
Parametrised serial pattern detector, successor to the fixed 4-bit matcher on the bit_stream path. Pattern width is generic. Pattern, don't-care mask and overlap mode are loadable at run time. Input bits are qualified by a valid strobe, and the block keeps a saturating count of matches for status readout.

Parameters:
PAT_W, 4, pattern/history width in bits (>= 2)
CNT_W, 8, match counter width in bits (>= 1)
DEF_PATTERN, 4'b1101 (PAT_W bits), pattern loaded at reset

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
bit_valid  in  1  bit_stream is sampled this cycle
bit_stream  in  1  serial data bit
cfg_load  in  1  load cfg_* this cycle
cfg_pattern  in  PAT_W  new pattern; bit PAT_W-1 = oldest bit
cfg_mask  in  PAT_W  1 = compare this position, 0 = don't care
cfg_overlap  in  1  1 = overlapping matches allowed
found  out  1  one-cycle match pulse
match_count  out  CNT_W  number of matches, saturating
count_sat  out  1  sticky: match_count reached all-ones

Behaviour:
- Reset (rst=1 at posedge, priority over everything): hist=0, fill=0, pattern=DEF_PATTERN, mask=all ones, overlap=1, found=0, match_count=0, count_sat=0.
- History update: on bit_valid=1, hist_next={hist[PAT_W-2:0], bit_stream}, so the newest bit goes to the LSB.
- Fill counter: counts accepted bits and saturates at PAT_W.
  - fill_next = min(fill+1, PAT_W) on bit_valid.
  - Unchanged when bit_valid=0.
- Match condition, evaluated only when bit_valid=1: fill_next==PAT_W AND ((hist_next ^ pattern) & mask)==0.
- found is registered. It is high exactly one cycle, the cycle after the posedge that sampled the completing bit (latency 1).
  - found=0 in any cycle following bit_valid=0, rst or cfg_load.
- Overlap mode (overlap=1): history and fill are kept after a match, so successive matches may share bits.
- Non-overlap mode (overlap=0): on a match, fill is forced to 0 (hist still updates). The next match needs PAT_W fresh bits.
- cfg_load=1 (rst=0):
  - pattern, mask and overlap take the cfg_* values.
  - hist=0, fill=0, match_count=0, count_sat=0.
  - A bit_valid in the same cycle is discarded.
  - Loads take effect from the next cycle.
- mask all zeros: every accepted bit matches once fill has reached PAT_W (non-overlap: every PAT_W bits).
- match_count increments by 1 in the cycle found is asserted, and holds at 2^CNT_W-1.
- count_sat is set when match_count becomes all-ones and is cleared only by rst or cfg_load.
- bit_valid=0 freezes hist and fill. Gaps of any length do not break a match in progress.
- Mid-stream rst or cfg_load discards the partial history. No match is possible until PAT_W new bits have been accepted.
- State is datapath-only plus fill. The fill counter acts as the state machine: FILLING (fill<PAT_W) or ARMED (fill==PAT_W). Non-overlap match returns it to FILLING.

Test Plan:
1. PAT_W=4, default config. Stream 1,1,0,1,1,0,1 with bit_valid=1 every cycle -> found pulses after bit 4 and after bit 7; match_count=2.
2. Same stream after cfg_load with pattern=1101, mask=1111, overlap=0 -> found only after bit 4; match_count=1.
3. Default config. Stream 1,1,0,1 with bit_valid low for 3 cycles between bits 2 and 3 -> single found pulse one cycle after bit 4 is sampled; no pulse during the gap.
4. cfg_load pattern=1001, mask=1001. Stream 1,1,1,1, then 0,1,1,0 -> found after bit 4 (hist 1111), no found at hist 0110.
5. CNT_W=2, pattern=1111, overlap=1. Stream of 8 ones -> found after bits 4 through 8; match_count goes 1,2,3,3,3; count_sat=1 from the third match onward.
6. Default config. Stream 1,1,0, then rst=1 for one cycle, then 1 -> no found. Then 1,1,0,1 -> found. Repeat using cfg_load instead of rst, with a bit_valid in the cfg_load cycle -> that bit is ignored; match_count is cleared.
